// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions used by the master, the response mux and the memory slaves.
// Holds transfer/response codes, the slave state type and a ready-state helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;

    typedef enum logic [2:0] {
        SLV_IDLE = 3'd0,
        SLV_WAIT = 3'd1,
        SLV_DATA = 3'd2,
        SLV_ERR1 = 3'd3,
        SLV_ERR2 = 3'd4
    } slv_state_t;

    // States in which the slave drives hreadyout high and may take a new address phase.
    function automatic logic is_ready_state(input slv_state_t s);
        return (s == SLV_IDLE) || (s == SLV_DATA) || (s == SLV_ERR2);
    endfunction

endpackage

// File: rtl/byte_ram.sv
// DEPTH x 8 storage for the AHB memory slave: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module byte_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [DEPTH];

    // Byte write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite byte-wide memory slave with configurable wait states and a two-cycle ERROR response.
// All bus outputs are registered; read data is captured at accept time with write forwarding.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic              hready,
    input  logic [7:0]        hwdata,
    output logic [7:0]        hrdata,
    output logic              hreadyout,
    output logic              hresp
);

    localparam int              RAM_AW    = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [2:0]      WAIT_LOAD = 3'(WAIT_STATES);

    slv_state_t        state_r;
    slv_state_t        state_nx_s;
    logic [2:0]        wcnt_r;
    logic [RAM_AW-1:0] addr_r;
    logic              write_r;
    logic [7:0]        hrdata_r;
    logic              hreadyout_r;
    logic              hresp_r;

    logic              accept_s;
    logic              err_s;
    logic              fwd_s;
    logic              ram_we_s;
    logic [7:0]        ram_rdata_s;

    // Only a ready state can take an address phase; WAIT/ERR1 never capture even if hready glitches.
    assign accept_s = hsel & hready & htrans[1] & is_ready_state(state_r);
    assign err_s    = ({1'b0, haddr} >= DEPTH_L) | (hsize != HSIZE_BYTE);
    assign ram_we_s = (state_r == SLV_DATA) & write_r;
    assign fwd_s    = ram_we_s & (addr_r == haddr[RAM_AW-1:0]);

    byte_ram #(
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (hclk),
        .we    (ram_we_s),
        .waddr (addr_r),
        .wdata (hwdata),
        .raddr (haddr[RAM_AW-1:0]),
        .rdata (ram_rdata_s)
    );

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            SLV_IDLE, SLV_DATA, SLV_ERR2: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_nx_s = SLV_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_nx_s = SLV_DATA;
                    end else begin
                        state_nx_s = SLV_WAIT;
                    end
                end else begin
                    state_nx_s = SLV_IDLE;
                end
            end
            SLV_WAIT: begin
                // <= guards against a zero count ever trapping the FSM in WAIT.
                if (wcnt_r <= 3'd1) begin
                    state_nx_s = SLV_DATA;
                end else begin
                    state_nx_s = SLV_WAIT;
                end
            end
            SLV_ERR1: begin
                state_nx_s = SLV_ERR2;
            end
            default: begin
                state_nx_s = SLV_IDLE;
            end
        endcase
    end

    // State, wait counter, captured address phase and registered bus outputs.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_r     <= SLV_IDLE;
            wcnt_r      <= 3'd0;
            addr_r      <= '0;
            write_r     <= 1'b0;
            hrdata_r    <= 8'h00;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
        end else begin
            state_r     <= state_nx_s;
            hreadyout_r <= is_ready_state(state_nx_s);
            hresp_r     <= ((state_nx_s == SLV_ERR1) || (state_nx_s == SLV_ERR2)) ?
                           HRESP_ERROR : HRESP_OKAY;

            if (accept_s && !err_s) begin
                wcnt_r <= WAIT_LOAD;
            end else if (state_r == SLV_WAIT) begin
                wcnt_r <= wcnt_r - 3'd1;
            end

            if (accept_s) begin
                addr_r  <= haddr[RAM_AW-1:0];
                write_r <= hwrite;
            end

            // A read accepted during a same-address write commit must see the new byte.
            if (accept_s && !err_s && !hwrite) begin
                hrdata_r <= fwd_s ? hwdata : ram_rdata_s;
            end
        end
    end

    assign hrdata    = hrdata_r;
    assign hreadyout = hreadyout_r;
    assign hresp     = hresp_r;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench for ahb_slave_mem: two instances (WAIT_STATES=1 and 0), each with
// its own stimulus, transaction-level reference model, scoreboard queue and monitor.
module tb_ahb_slave_mem;

    typedef struct {
        bit         err;
        bit         wr;
        logic [7:0] rdata;
    } exp_t;

    logic hclk;
    int   total;
    int   bad;
    bit   done_s [2];

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int WS = (gi == 0) ? 1 : 0;

        logic       hreset, hsel, hwrite, hready, stall;
        logic [5:0] haddr;
        logic [1:0] htrans;
        logic [2:0] hsize;
        logic [7:0] hwdata, hrdata;
        logic       hreadyout, hresp;

        logic [7:0] mem_m [32];
        logic [7:0] hrdata_m;
        exp_t       q [$];
        bit         active;
        int         cyc;
        exp_t       cur;

        assign hready = stall ? 1'b0 : hreadyout;

        ahb_slave_mem #(
            .ADDR_W      (6),
            .DEPTH       (32),
            .WAIT_STATES (WS)
        ) u_dut (
            .hclk      (hclk),
            .hreset    (hreset),
            .hsel      (hsel),
            .haddr     (haddr),
            .htrans    (htrans),
            .hwrite    (hwrite),
            .hsize     (hsize),
            .hready    (hready),
            .hwdata    (hwdata),
            .hrdata    (hrdata),
            .hreadyout (hreadyout),
            .hresp     (hresp)
        );

        task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s inst%0d: got=%h want=%h t=%0t", name, gi, got, want, $time);
            end
        endtask

        // Issue one transfer; the model is updated in transfer order and the expectation queued.
        task automatic do_xfer(input logic [5:0] a, input logic wr, input logic [2:0] sz,
                               input logic [7:0] d);
            exp_t e;
            int   n;
            bit   err;
            err = (a >= 6'd32) || (sz != 3'd0);
            if (!err) begin
                if (wr) mem_m[a[4:0]] = d;
                else    hrdata_m = mem_m[a[4:0]];
            end
            e.err = err; e.wr = wr; e.rdata = hrdata_m;
            q.push_back(e);
            hsel = 1'b1; haddr = a; htrans = 2'd2; hwrite = wr; hsize = sz;
            n = 0;
            @(negedge hclk);
            while (!hready && n < 50) begin
                @(negedge hclk);
                n++;
            end
            total++;
            if (n >= 50) begin
                bad++;
                $display("FAIL accept_timeout inst%0d: hready=%b want 1", gi, hready);
            end
            @(posedge hclk); #1;
            hwdata = wr ? d : 8'($urandom);
            htrans = 2'd0;
            hsel   = 1'($urandom);
        endtask

        task automatic idle(input int n);
            for (int i = 0; i < n; i++) begin
                hsel   = 1'($urandom);
                htrans = 2'($urandom_range(0, 1));
                @(posedge hclk); #1;
            end
        endtask

        // Monitor: follows each accepted transfer through its data phase.
        initial begin
            logic exp_rdy, exp_resp;
            int   last;
            active = 1'b0;
            cyc    = 0;
            forever begin
                @(negedge hclk);
                if (hreset) begin
                    active = 1'b0;
                end else begin
                    if (active) begin
                        cyc++;
                        last     = cur.err ? 2 : WS + 1;
                        exp_rdy  = (cyc == last);
                        exp_resp = cur.err;
                        total++;
                        if (hreadyout !== exp_rdy || hresp !== exp_resp) begin
                            bad++;
                            $display("FAIL dphase inst%0d cyc%0d: got rdy=%b resp=%b want rdy=%b resp=%b",
                                     gi, cyc, hreadyout, hresp, exp_rdy, exp_resp);
                        end
                        if (cyc == last) begin
                            chk(cur.wr ? "hrdata_hold_w" : (cur.err ? "hrdata_hold_e" : "rdata"),
                                hrdata, cur.rdata);
                            active = 1'b0;
                        end
                    end else begin
                        total++;
                        if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
                            bad++;
                            $display("FAIL idle_okay inst%0d: got rdy=%b resp=%b want rdy=1 resp=0",
                                     gi, hreadyout, hresp);
                        end
                    end
                    if (hsel && hready && htrans[1]) begin
                        total++;
                        if (q.size() == 0) begin
                            bad++;
                            $display("FAIL sb_empty inst%0d: got accept want none", gi);
                        end else begin
                            cur    = q.pop_front();
                            active = 1'b1;
                            cyc    = 0;
                        end
                    end
                end
            end
        end

        // Stimulus.
        initial begin
            logic [5:0] a;
            hreset = 1'b1; hsel = 1'b0; haddr = 6'd0; htrans = 2'd0; hwrite = 1'b0;
            hsize = 3'd0; hwdata = 8'd0; stall = 1'b0;
            hrdata_m = 8'h00;
            repeat (2) @(posedge hclk);
            #1;
            chk("rst_hreadyout", {7'd0, hreadyout}, 8'd1);
            chk("rst_hresp", {7'd0, hresp}, 8'd0);
            chk("rst_hrdata", hrdata, 8'h00);
            hreset = 1'b0;
            @(posedge hclk); #1;

            for (int i = 0; i < 32; i++) begin
                do_xfer(6'(i), 1'b1, 3'd0, 8'($urandom));
                if ($urandom_range(0, 1) == 0) idle(1);
            end
            idle(2);

            do_xfer(6'd3, 1'b1, 3'd0, 8'hA5);
            idle(2);
            do_xfer(6'd3, 1'b0, 3'd0, 8'h00);
            idle(2);
            do_xfer(6'd7, 1'b1, 3'd0, 8'h3C);
            do_xfer(6'd7, 1'b0, 3'd0, 8'h00);
            idle(1);
            do_xfer(6'd40, 1'b0, 3'd0, 8'h00);
            do_xfer(6'd40, 1'b0, 3'd0, 8'h00);
            idle(1);
            do_xfer(6'd5, 1'b1, 3'd1, 8'hFF);
            do_xfer(6'd5, 1'b0, 3'd0, 8'h00);
            idle(4);

            // Bus stalled by another slave: NONSEQ write must not be captured.
            stall = 1'b1; hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd0;
            haddr = 6'd9; hwdata = ~mem_m[9];
            repeat (3) begin @(posedge hclk); #1; end
            htrans = 2'd0; stall = 1'b0;
            idle(1);
            do_xfer(6'd9, 1'b0, 3'd0, 8'h00);
            idle(2);

            // Reset in the first data-phase cycle of a read.
            do_xfer(6'd3, 1'b0, 3'd0, 8'h00);
            #3;
            hreset = 1'b1;
            #1;
            chk("midrst_hreadyout", {7'd0, hreadyout}, 8'd1);
            chk("midrst_hresp", {7'd0, hresp}, 8'd0);
            chk("midrst_hrdata", hrdata, 8'h00);
            hrdata_m = 8'h00;
            hsel = 1'b0;
            @(posedge hclk); #1;
            hreset = 1'b0;
            idle(2);

            for (int i = 0; i < 150; i++) begin
                a = 6'($urandom_range(0, 63));
                if (a > 6'd40) a = a & 6'd31;
                do_xfer(a, 1'($urandom), ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                        8'($urandom));
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            end
            idle(WS + 4);
            chk("sb_drained", 8'(q.size()), 8'd0);
            done_s[gi] = 1'b1;
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        fork
            wait (done_s[0] && done_s[1]);
            #100000;
        join_any
        if (!(done_s[0] && done_s[1])) begin
            total++;
            bad++;
            $display("FAIL global_timeout: done=%b%b want 11", done_s[1], done_s[0]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
